// File: rtl/record_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : record_packer                                              |
// | Description : Buffers 47-bit tagger records in a small FIFO and          |
// |               serializes each one into three 16-bit words on a           |
// |               valid/ready stream. Records that arrive while the FIFO     |
// |               is full are dropped; the next accepted record carries a    |
// |               loss flag in bit 15 of its first word.                     |
// | Options     : RECORD_PACKER_LOSS_COUNT_EN adds a saturating 16-bit       |
// |               dropped-record counter on port lost_count.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module record_packer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  record_rdy,
  input  logic [46:0]           record,
  output logic [15:0]           word,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  word_last,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
`ifdef RECORD_PACKER_LOSS_COUNT_EN
  output logic [15:0]           lost_count,
`endif
  input  logic                  clear_overflow
);

  localparam int unsigned           c_DEPTH_INT = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_DEPTH     = c_DEPTH_INT[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2,
    ST_W2   = 2'd3
  } state_t;

  // FIFO storage: each entry is {loss, record}
  logic [47:0]           r_mem [c_DEPTH_INT];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_pending_loss;
  logic                  r_overflow;

  // Serializer state; only the two lower words need to be kept once the
  // first word has been loaded into the output register.
  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_shift;
  logic [15:0]           r_word;
  logic                  r_word_last;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_handshake;
  logic [47:0]           w_head;

  assign w_full      = (r_count == c_DEPTH);
  assign w_empty     = (r_count == '0);
  // Full means drop even if the serializer pops in the same cycle.
  assign w_push      = record_rdy && !w_full;
  assign w_drop      = record_rdy &&  w_full;
  assign w_handshake = (r_state != ST_IDLE) && word_ready;
  assign w_head      = r_mem[r_rd_ptr];

  // Pop the head when idle, or when the last word of a record is taken so
  // records follow each other without a bubble.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_W2) && word_ready));

  // FIFO storage write; contents need no reset since pointers are cleared
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_pending_loss, record};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Loss tracking: a drop arms the flag, the next accepted push consumes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending_loss <= 1'b0;
    end else if (w_drop) begin
      r_pending_loss <= 1'b1;
    end else if (w_push) begin
      r_pending_loss <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef RECORD_PACKER_LOSS_COUNT_EN
  logic [15:0] r_lost_count;

  // Saturating dropped-record counter; a clear coinciding with a drop gives 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lost_count <= 16'h0000;
    end else if (clear_overflow) begin
      r_lost_count <= w_drop ? 16'h0001 : 16'h0000;
    end else if (w_drop && (r_lost_count != 16'hFFFF)) begin
      r_lost_count <= r_lost_count + 16'h0001;
    end
  end

  assign lost_count = r_lost_count;
`endif

  // Serializer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Serializer next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pop) w_state_nxt = ST_W0;
      ST_W0:   if (word_ready) w_state_nxt = ST_W1;
      ST_W1:   if (word_ready) w_state_nxt = ST_W2;
      ST_W2: begin
        if (word_ready) begin
          w_state_nxt = w_pop ? ST_W0 : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output word register: loaded on pop, advanced only on a handshake so
  // the word stays stable under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word      <= 16'h0000;
      r_word_last <= 1'b0;
      r_shift     <= 32'h0000_0000;
    end else if (w_pop) begin
      r_word      <= w_head[47:32];
      r_word_last <= 1'b0;
      r_shift     <= w_head[31:0];
    end else if (w_handshake) begin
      case (r_state)
        ST_W0: begin
          r_word      <= r_shift[31:16];
          r_word_last <= 1'b0;
        end
        ST_W1: begin
          r_word      <= r_shift[15:0];
          r_word_last <= 1'b1;
        end
        default: begin
          r_word_last <= 1'b0;
        end
      endcase
    end
  end

  assign word       = r_word;
  assign word_last  = r_word_last;
  assign word_valid = (r_state != ST_IDLE);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_record_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_record_packer                                           |
// | Description : Directed self-checking bench for record_packer             |
// |               (DEPTH_LOG2 = 2). Honours RECORD_PACKER_LOSS_COUNT_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_record_packer;

  logic        clk;
  logic        reset;
  logic        record_rdy;
  logic [46:0] record;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        clear_overflow;
`ifdef RECORD_PACKER_LOSS_COUNT_EN
  logic [15:0] lost_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] q_word [$];
  logic        q_last [$];

  record_packer #(.DEPTH_LOG2(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .record_rdy     (record_rdy),
    .record         (record),
    .word           (word),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_last      (word_last),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
`ifdef RECORD_PACKER_LOSS_COUNT_EN
    .lost_count     (lost_count),
`endif
    .clear_overflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [46:0] mkrec(input int i);
    return {15'(i), 16'(16'hA000 + i), 16'(16'hB000 + i)};
  endfunction

  // Collect up to n handshaken words within a cycle budget
  task automatic collect(input int n, input int budget);
    q_word.delete();
    q_last.delete();
    for (int i = 0; i < budget && q_word.size() < n; i++) begin
      if (word_valid && word_ready) begin
        q_word.push_back(word);
        q_last.push_back(word_last);
      end
      cyc();
    end
  endtask

  initial begin
    logic [15:0] prev_word;
    logic        prev_valid;
    logic        prev_ready;
    int          hs;
    int          words;
    int          max_cnt;
    logic        started;
    logic        gap;

    reset = 1'b1; record_rdy = 1'b0; record = '0;
    word_ready = 1'b0; clear_overflow = 1'b0;
    cyc(); cyc();
    // ---- reset state
    check("rst_valid", word_valid, 0);
    check("rst_last",  word_last,  0);
    check("rst_word",  word,       0);
    check("rst_ovf",   overflow,   0);
    check("rst_count", fifo_count, 0);
`ifdef RECORD_PACKER_LOSS_COUNT_EN
    check("rst_lost",  lost_count, 0);
`endif
    reset = 1'b0;
    cyc();

    // ---- single record, latency and word order
    word_ready = 1'b1;
    record_rdy = 1'b1; record = 47'h1234_5678_9ABC;
    cyc();
    record_rdy = 1'b0;
    check("lat_n1_valid", word_valid, 0);
    check("lat_n1_count", fifo_count, 1);
    cyc();
    check("w0_valid", word_valid, 1);
    check("w0_word",  word, 16'h1234);
    check("w0_last",  word_last, 0);
    cyc();
    check("w1_word",  word, 16'h5678);
    check("w1_last",  word_last, 0);
    cyc();
    check("w2_word",  word, 16'h9ABC);
    check("w2_last",  word_last, 1);
    cyc();
    check("single_idle",  word_valid, 0);
    check("single_count", fifo_count, 0);

    // ---- backpressure: ready toggles every cycle
    hs = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_word = '0;
    q_word.delete(); q_last.delete();
    for (int j = 0; j < 20; j++) begin
      record_rdy = (j == 0);
      record     = 47'h0ABC_DEF0_1357;
      word_ready = j[0];
      if (prev_valid && !prev_ready) begin
        check("bp_stable", word, prev_word);
      end
      if (word_valid && word_ready) begin
        hs++;
        q_word.push_back(word);
        q_last.push_back(word_last);
      end
      prev_valid = word_valid; prev_ready = word_ready; prev_word = word;
      cyc();
    end
    record_rdy = 1'b0;
    check("bp_handshakes", hs, 3);
    if (q_word.size() == 3) begin
      check("bp_word0", q_word[0], 16'h0ABC);
      check("bp_word1", q_word[1], 16'hDEF0);
      check("bp_word2", q_word[2], 16'h1357);
      check("bp_last2", q_last[2], 1);
    end

    // ---- overflow: 6 records with word_ready low
    word_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      record_rdy = 1'b1; record = mkrec(i);
      cyc();
    end
    record_rdy = 1'b0;
    check("ovf_count", fifo_count, 4);
    check("ovf_flag",  overflow,   1);
`ifdef RECORD_PACKER_LOSS_COUNT_EN
    check("ovf_lost",  lost_count, 1);
`endif
    word_ready = 1'b1;
    collect(3, 10);
    word_ready = 1'b0;
    check("ovf_r1_n", q_word.size(), 3);
    if (q_word.size() == 3) begin
      check("ovf_r1_w0", q_word[0], 16'h0001);
      check("ovf_r1_w2", q_word[2], 16'hB001);
      check("ovf_r1_l2", q_last[2], 1);
    end
    record_rdy = 1'b1; record = mkrec(7);
    cyc();
    record_rdy = 1'b0;
    check("ovf_refill_count", fifo_count, 4);
    word_ready = 1'b1;
    collect(15, 60);
    check("ovf_drain_n", q_word.size(), 15);
    if (q_word.size() == 15) begin
      check("ovf_r2_w0", q_word[0],  16'h0002);
      check("ovf_r3_w0", q_word[3],  16'h0003);
      check("ovf_r5_w0", q_word[9],  16'h0005);
      check("ovf_r7_w0", q_word[12], 16'h8007);
      check("ovf_r7_w2", q_word[14], 16'hB007);
    end
    cyc();
    check("ovf_drained_valid", word_valid, 0);
    check("ovf_drained_count", fifo_count, 0);
    check("ovf_still_set",     overflow,   1);

    // ---- clear alone, then clear coinciding with a drop
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    check("clr_ovf", overflow, 0);
`ifdef RECORD_PACKER_LOSS_COUNT_EN
    check("clr_lost", lost_count, 0);
`endif
    word_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      record_rdy = 1'b1; record = mkrec(30 + i);
      clear_overflow = (i == 6);
      cyc();
    end
    record_rdy = 1'b0; clear_overflow = 1'b0;
    check("clrdrop_ovf",   overflow,   1);
    check("clrdrop_count", fifo_count, 4);
`ifdef RECORD_PACKER_LOSS_COUNT_EN
    check("clrdrop_lost",  lost_count, 1);
`endif

    // ---- reset mid-record
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst2_ovf",   overflow,   0);
    check("rst2_count", fifo_count, 0);
    word_ready = 1'b1;
    record_rdy = 1'b1; record = 47'h0111_2222_3333;
    cyc();
    record_rdy = 1'b0;
    cyc();
    check("mid_w0", word, 16'h0111);
    cyc();
    check("mid_w1", word, 16'h2222);
    reset = 1'b1;
    #1;
    check("mid_valid_drop", word_valid, 0);
    check("mid_count",      fifo_count, 0);
    check("mid_word_clr",   word,       0);
    cyc();
    reset = 1'b0;
    check("mid_idle", word_valid, 0);
    record_rdy = 1'b1; record = 47'h0444_5555_6666;
    cyc();
    record_rdy = 1'b0;
    collect(4, 10);
    check("mid_next_n", q_word.size(), 3);
    if (q_word.size() == 3) begin
      check("mid_next_w0", q_word[0], 16'h0444);
      check("mid_next_w1", q_word[1], 16'h5555);
      check("mid_next_w2", q_word[2], 16'h6666);
      check("mid_next_l2", q_last[2], 1);
    end

    // ---- back-to-back: one record every 3rd cycle
    word_ready = 1'b1; words = 0; max_cnt = 0; started = 1'b0; gap = 1'b0;
    q_word.delete();
    for (int i = 0; i < 36; i++) begin
      record_rdy = ((i % 3) == 0) && (i < 24);
      record     = mkrec(40 + i / 3);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (word_valid) begin
        started = 1'b1;
        words++;
        q_word.push_back(word);
      end else if (started && words < 24) begin
        gap = 1'b1;
      end
      cyc();
    end
    record_rdy = 1'b0;
    check("b2b_words",   words,   24);
    check("b2b_gap",     gap,     0);
    check("b2b_max_cnt", (max_cnt <= 1), 1);
    if (q_word.size() == 24) begin
      check("b2b_r0_w0", q_word[0],  16'h0028);
      check("b2b_r7_w0", q_word[21], 16'h002F);
      check("b2b_r7_w2", q_word[23], 16'hB02F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/record_packer.md
# record_packer

Downstream stage of the tagger top level. It takes each 47-bit record strobed out with `record_rdy` and buffers it in a small FIFO. It then serializes the record into three 16-bit words on a valid/ready stream feeding the host-interface word FIFO. The tagger cannot be stalled, so records that arrive while the buffer is full are dropped, and the next accepted record is flagged to mark the gap.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 records.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `record_rdy` in 1: single-cycle strobe; `record` is valid in that cycle.
- `record` in 47: event record from the tagger.
- `word` out 16: output word.
- `word_valid` out 1: `word` is valid.
- `word_ready` in 1: consumer accepts `word` in a cycle where `word_valid` and `word_ready` are both high.
- `word_last` out 1: high with the third word of a record.
- `fifo_count` out DEPTH_LOG2+1: number of records held in the FIFO, excluding the record being serialized.
- `overflow` out 1: sticky; set when any record has been dropped.
- `clear_overflow` in 1: clears `overflow`; synchronous, level-sensitive.

## Operation
- **FIFO entry:** 48 bits, `{loss, record[46:0]}`.
- **Push:**
  - Condition: `record_rdy` is high and `fifo_count` < 2^DEPTH_LOG2.
  - A pop in the same cycle does not free a slot for the push, so full means drop.
- **Drop** (`record_rdy` high while full):
  - The record is discarded.
  - `overflow` is set.
  - Internal `pending_loss` is set.
- **Loss flag:**
  - An accepted push stores `loss = pending_loss`, then clears `pending_loss`.
  - When a drop and a push cannot coincide (they never do), there is no conflict.
- **`clear_overflow`:** clears `overflow` only. It does not affect `pending_loss`. If a drop occurs in the same cycle, the set wins.
- **Serializer FSM:** states IDLE, W0, W1, W2.
  - IDLE: if the FIFO is non-empty, pop the head into the 48-bit shift register and go to W0.
  - W0: `word = {loss, record[46:32]}`; on handshake go to W1.
  - W1: `word = record[31:16]`; on handshake go to W2.
  - W2: `word = record[15:0]` with `word_last` = 1. On handshake:
    - FIFO non-empty: pop and go to W0 (back-to-back, no bubble).
    - FIFO empty: go to IDLE.
- **Output signals:**
  - `word_valid` is high in W0, W1 and W2.
  - `word` and `word_last` are registered and held stable while `word_valid` is high and `word_ready` is low.
- **Simultaneous push and pop:** `fifo_count` is unchanged; pointers wrap modulo 2^DEPTH_LOG2.
- **Reset** (any time, including mid-record):
  - FSM goes to IDLE.
  - Pointers and `fifo_count` are zeroed; FIFO contents are discarded.
  - `pending_loss` and `overflow` are cleared.
  - A partially sent record is abandoned; the consumer sees no further words of it.

## Timing
- **Reset values:**
  - `word_valid`, `word_last`, `overflow` = 0.
  - `word` = 16'h0000.
  - `fifo_count` = 0.
- **Latency:** with the block empty and idle, `record_rdy` in cycle N gives `word_valid` high in cycle N+2.
- **Throughput:** one word per cycle while `word_ready` is high. A sustained record rate above 1 per 3 cycles eventually overflows.
- **`fifo_count` update:** registered; updates the cycle after a push or pop.
- **`overflow` update:** registered; visible the cycle after the drop.

## Configuration
- **`RECORD_PACKER_LOSS_COUNT_EN` defined:**
  - Adds output `lost_count` out 16: number of dropped records, saturating at 16'hFFFF.
  - `lost_count` is cleared by `reset` and by `clear_overflow`. If a drop occurs in the same cycle as the clear, the count becomes 1.
- **`RECORD_PACKER_LOSS_COUNT_EN` not defined:** `lost_count` port and its counter are absent; all other behaviour is identical.

## Test plan
- **Single record:** reset; `record` = 47'h1234_5678_9ABC strobed with `word_ready` held high -> 3 consecutive words 16'h1234, 16'h5678, 16'h9ABC with `word_last` on the third; first word 2 cycles after the strobe.
- **Backpressure:** `word_ready` toggles 0/1 each cycle during a record -> each word held stable until accepted; exactly 3 handshakes per record, no duplicates.
- **Overflow:**
  - Stimulus: `DEPTH_LOG2` = 2, `word_ready` = 0; strobe 6 records.
  - Required: `fifo_count` = 4; `overflow` = 1; `lost_count` = 1 (4 in the FIFO, 1 in the shift register, 1 dropped).
  - Then strobe a 7th record after draining one -> that record's first word has bit 15 = 1.
- **Back-to-back:** 8 records strobed every 3rd cycle with `word_ready` = 1 -> 24 contiguous valid words with no gap; `fifo_count` never exceeds 1.
- **Reset mid-record:** assert `reset` after the first handshake of a record -> `word_valid` drops immediately; `fifo_count` = 0; the next record is emitted in full from W0.
- **Clear vs drop:** `clear_overflow` asserted in the same cycle as a drop -> `overflow` stays 1; `lost_count` = 1.
